dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single D$ request port between two requesters: the MEM stage (requester 0) and the page-table walker (requester 1).
- Latches the winning request and holds it stable on the dc_* port until the D$ signals completion.
- Routes the response back only to the requester that owns the transaction.
- Applies round-robin fairness and inserts a one-cycle release bubble between transactions.
- Flags hung transactions with a watchdog.

Parameters:
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, read/write data width.
- TIMEOUT_CYCLES, 1024, cycles in BUSY before timeout_err sets; must be >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- m_en  in  1  MEM request valid; held until its done, or dropped to abort.
- m_addr  in  ADDR_WIDTH  MEM address.
- m_write_en  in  1  MEM write=1/read=0.
- m_wdata  in  DATA_WIDTH  MEM write data.
- m_wlen  in  2  MEM log2(bytes).
- m_rdata  out  DATA_WIDTH  read data to MEM.
- m_rvalid  out  1  MEM read complete.
- m_write_done  out  1  MEM write complete.
- m_page_fault  out  1  fault qualifier for MEM completion.
- p_en, p_addr, p_write_en, p_wdata, p_wlen  in  as m_*  page-table-walker request.
- p_rdata, p_rvalid, p_write_done, p_page_fault  out  as m_*  page-table-walker response.
- dc_en  out  1  D$ request valid.
- dc_in_addr  out  ADDR_WIDTH  latched address.
- dc_write_en  out  1  latched write flag.
- dc_in_wdata  out  DATA_WIDTH  latched write data.
- dc_in_wlen  out  2  latched length.
- dc_out_rdata  in  DATA_WIDTH  D$ read data.
- dc_out_rvalid  in  1  D$ read done.
- dc_out_write_done  in  1  D$ write done.
- dc_out_page_fault  in  1  D$ fault qualifier.
- owner  out  1  current/last granted requester (0=MEM, 1=PTW).
- busy  out  1  1 while in BUSY.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, BUSY, RELEASE.
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=1 (so MEM wins the first tie), latched request fields=0, aborted=0, watchdog=0, timeout_err=0.
  - All m_*/p_* response outputs and dc_en are 0.
- IDLE:
  - If m_en or p_en is high, grant at the next edge and enter BUSY.
  - Only one requesting: that requester wins.
  - Both requesting: the requester != owner wins (round-robin).
  - At the grant edge: latch addr, write_en, wdata and wlen; set owner=winner; clear aborted and watchdog.
- Outputs from state:
  - dc_en = (state==BUSY). All dc_in_* outputs are driven from the latch, never combinationally from the requester inputs.
  - Request-to-dc_en latency is 1 cycle.
- Completion: done = dc_out_rvalid | dc_out_write_done, sampled only in BUSY.
  - In the done cycle, if !aborted, forward combinationally to the owner: rdata=dc_out_rdata, rvalid, write_done, page_fault=dc_out_page_fault&done.
  - The non-owner's rvalid, write_done and page_fault are always 0; rdata outputs are 0 when not valid.
  - Next state is RELEASE.
- RELEASE: dc_en=0 for exactly 1 cycle, then IDLE. Minimum spacing between transactions is 3 cycles (grant, done, release).
- Abort: if the owner's *_en is low at any BUSY cycle edge before done:
  - set aborted=1;
  - the transaction continues with latched fields until done;
  - the response is discarded (no valid pulse to anyone).
  - A requester that re-raises en while aborted is served only after RELEASE.
- Done and abort in the same cycle: the response is still forwarded (the done cycle wins).
- Non-owner requests during BUSY or RELEASE are held pending (requesters keep en high); no queueing inside the arbiter.
- Watchdog:
  - Increments each BUSY cycle and saturates.
  - When it reaches TIMEOUT_CYCLES, timeout_err=1 and stays set until reset; the FSM continues to wait.
- dc_out_* activity outside BUSY is ignored and produces no response pulses.
- Reset mid-transaction: immediate return to IDLE; dc_en drops asynchronously; no response is delivered.

Test Plan:
- Single MEM read: m_en=1, addr=0x1000, write_en=0; D$ returns rdata=0xDEADBEEF with rvalid 3 cycles after dc_en -> dc_en rises 1 cycle after m_en with dc_in_addr=0x1000; m_rvalid=1 for 1 cycle with m_rdata=0xDEADBEEF; p_rvalid=0; one cycle of dc_en=0 follows.
- Contention/fairness: m_en and p_en both held from reset -> grants MEM, then PTW, then MEM, in alternation; owner toggles 0,1,0; each dc_en window carries that requester's address.
- Input change after grant: PTW write with p_addr=0x2000, wdata=0x55; p_addr changes to 0x3000 during BUSY -> dc_in_addr stays 0x2000; p_write_done pulses once.
- Abort: MEM read granted, m_en dropped 1 cycle later, rvalid after 4 cycles -> dc_en stays high until rvalid; m_rvalid never pulses; p_en, if pending, is granted after RELEASE.
- Page fault: PTW read completes with dc_out_rvalid=1 and dc_out_page_fault=1 -> p_page_fault=1 and p_rvalid=1 in the same cycle; m_page_fault=0.
- Watchdog/reset: TIMEOUT_CYCLES=8, D$ never responds -> timeout_err=1 after the 8th BUSY cycle; asserting reset=0 mid-BUSY clears dc_en, busy and timeout_err immediately.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// Two-way arbiter sharing the single D$ request port between the MEM stage (0)
// and the page-table walker (1): latched requests, round-robin, release bubble, watchdog.
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m_en,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic                  m_write_en,
    input  logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [1:0]            m_wlen,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  m_rvalid,
    output logic                  m_write_done,
    output logic                  m_page_fault,

    input  logic                  p_en,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    input  logic                  p_write_en,
    input  logic [DATA_WIDTH-1:0] p_wdata,
    input  logic [1:0]            p_wlen,
    output logic [DATA_WIDTH-1:0] p_rdata,
    output logic                  p_rvalid,
    output logic                  p_write_done,
    output logic                  p_page_fault,

    output logic                  dc_en,
    output logic [ADDR_WIDTH-1:0] dc_in_addr,
    output logic                  dc_write_en,
    output logic [DATA_WIDTH-1:0] dc_in_wdata,
    output logic [1:0]            dc_in_wlen,
    input  logic [DATA_WIDTH-1:0] dc_out_rdata,
    input  logic                  dc_out_rvalid,
    input  logic                  dc_out_write_done,
    input  logic                  dc_out_page_fault,

    output logic                  owner,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    state_t          state, state_nxt;
    logic            aborted;
    logic [WD_W-1:0] wdog;
    logic            done, grant, winner, owner_en, fwd;

    always_comb begin
        done     = dc_out_rvalid | dc_out_write_done;
        grant    = (state == IDLE) && (m_en || p_en);
        // On a tie the requester that did not own the last transaction wins.
        winner   = (m_en && p_en) ? ~owner : p_en;
        owner_en = owner ? p_en : m_en;
        fwd      = (state == BUSY) && done && !aborted;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (done)  state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b1;
            dc_in_addr  <= '0;
            dc_write_en <= 1'b0;
            dc_in_wdata <= '0;
            dc_in_wlen  <= '0;
            aborted     <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner       <= winner;
                dc_in_addr  <= winner ? p_addr     : m_addr;
                dc_write_en <= winner ? p_write_en : m_write_en;
                dc_in_wdata <= winner ? p_wdata    : m_wdata;
                dc_in_wlen  <= winner ? p_wlen     : m_wlen;
                aborted     <= 1'b0;
                wdog        <= '0;
            end
            if (state == BUSY) begin
                // A dropped request keeps the D$ transaction alive but kills its response.
                if (!done && !owner_en)
                    aborted <= 1'b1;
                if (wdog != WD_MAX)
                    wdog <= wdog + WD_W'(1);
                if (wdog == WD_MAX - WD_W'(1))
                    timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        dc_en        = (state == BUSY);
        busy         = (state == BUSY);

        m_rvalid     = fwd && !owner && dc_out_rvalid;
        m_write_done = fwd && !owner && dc_out_write_done;
        m_page_fault = fwd && !owner && dc_out_page_fault;
        m_rdata      = m_rvalid ? dc_out_rdata : '0;

        p_rvalid     = fwd && owner && dc_out_rvalid;
        p_write_done = fwd && owner && dc_out_write_done;
        p_page_fault = fwd && owner && dc_out_page_fault;
        p_rdata      = p_rvalid ? dc_out_rdata : '0;
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with hand-computed expectations.
module tb_dcache_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          m_en, m_write_en, p_en, p_write_en;
    logic [AW-1:0] m_addr, p_addr;
    logic [DW-1:0] m_wdata, p_wdata;
    logic [1:0]    m_wlen, p_wlen;
    logic [DW-1:0] m_rdata, p_rdata;
    logic          m_rvalid, m_write_done, m_page_fault;
    logic          p_rvalid, p_write_done, p_page_fault;
    logic          dc_en, dc_write_en;
    logic [AW-1:0] dc_in_addr;
    logic [DW-1:0] dc_in_wdata;
    logic [1:0]    dc_in_wlen;
    logic [DW-1:0] dc_out_rdata;
    logic          dc_out_rvalid, dc_out_write_done, dc_out_page_fault;
    logic          owner, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m_en(m_en), .m_addr(m_addr), .m_write_en(m_write_en), .m_wdata(m_wdata), .m_wlen(m_wlen),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_write_done(m_write_done), .m_page_fault(m_page_fault),
        .p_en(p_en), .p_addr(p_addr), .p_write_en(p_write_en), .p_wdata(p_wdata), .p_wlen(p_wlen),
        .p_rdata(p_rdata), .p_rvalid(p_rvalid), .p_write_done(p_write_done), .p_page_fault(p_page_fault),
        .dc_en(dc_en), .dc_in_addr(dc_in_addr), .dc_write_en(dc_write_en), .dc_in_wdata(dc_in_wdata),
        .dc_in_wlen(dc_in_wlen), .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid),
        .dc_out_write_done(dc_out_write_done), .dc_out_page_fault(dc_out_page_fault),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_en = 0; m_addr = '0; m_write_en = 0; m_wdata = '0; m_wlen = '0;
        p_en = 0; p_addr = '0; p_write_en = 0; p_wdata = '0; p_wlen = '0;
        dc_out_rdata = '0; dc_out_rvalid = 0; dc_out_write_done = 0; dc_out_page_fault = 0;
        #12;
        checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL reset_dc_en got %b exp 0", dc_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b exp 1", owner); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_err); end
        checks++; if (dc_in_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", dc_in_addr); end
        checks++; if ({m_rvalid, p_rvalid, m_write_done, p_write_done} !== 4'b0)
            begin errors++; $display("FAIL reset_resp got %b exp 0000", {m_rvalid, p_rvalid, m_write_done, p_write_done}); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        m_en = 1; m_addr = 64'h1000; m_write_en = 0;
        #1;
        checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL sr_pre_dc_en got %b exp 0", dc_en); end
        tick();
        checks++; if (dc_en !== 1'b1) begin errors++; $display("FAIL sr_dc_en got %b exp 1", dc_en); end
        checks++; if (dc_in_addr !== 64'h1000) begin errors++; $display("FAIL sr_addr got %h exp 1000", dc_in_addr); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL sr_owner got %b exp 0", owner); end
        tick();
        tick();
        dc_out_rvalid = 1; dc_out_rdata = 64'hDEADBEEF;
        #1;
        checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL sr_m_rvalid got %b exp 1", m_rvalid); end
        checks++; if (m_rdata !== 64'hDEADBEEF) begin errors++; $display("FAIL sr_m_rdata got %h exp deadbeef", m_rdata); end
        checks++; if (p_rvalid !== 1'b0) begin errors++; $display("FAIL sr_p_rvalid got %b exp 0", p_rvalid); end
        tick();
        dc_out_rvalid = 0; dc_out_rdata = '0; m_en = 0;
        #1;
        checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL sr_release got %b exp 0", dc_en); end
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL sr_rvalid_once got %b exp 0", m_rvalid); end
        tick();
    endtask

    task automatic test_fairness();
        logic exp_own;
        do_reset();
        m_en = 1; m_addr = 64'hA000; p_en = 1; p_addr = 64'hB000; p_write_en = 0;
        for (int i = 0; i < 3; i++) begin
            exp_own = (i % 2) != 0;
            tick();
            checks++; if (dc_en !== 1'b1) begin errors++; $display("FAIL rr_dc_en[%0d] got %b exp 1", i, dc_en); end
            checks++; if (owner !== exp_own) begin errors++; $display("FAIL rr_owner[%0d] got %b exp %b", i, owner, exp_own); end
            checks++; if (dc_in_addr !== (exp_own ? 64'hB000 : 64'hA000))
                begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", i, dc_in_addr, exp_own ? 64'hB000 : 64'hA000); end
            dc_out_rvalid = 1; dc_out_rdata = 64'h100 + 64'(i);
            #1;
            checks++; if ({m_rvalid, p_rvalid} !== {!exp_own, exp_own})
                begin errors++; $display("FAIL rr_resp[%0d] got %b exp %b", i, {m_rvalid, p_rvalid}, {!exp_own, exp_own}); end
            tick();
            dc_out_rvalid = 0;
            #1;
            checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL rr_release[%0d] got %b exp 0", i, dc_en); end
            tick();
            checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d] got %b exp 0", i, dc_en); end
        end
        m_en = 0; p_en = 0;
        tick();
    endtask

    task automatic test_input_change();
        p_en = 1; p_addr = 64'h2000; p_write_en = 1; p_wdata = 64'h55; p_wlen = 2'd3;
        tick();
        checks++; if (dc_in_addr !== 64'h2000) begin errors++; $display("FAIL ic_addr got %h exp 2000", dc_in_addr); end
        checks++; if ({dc_write_en, dc_in_wlen} !== 3'b111) begin errors++; $display("FAIL ic_we_len got %b exp 111", {dc_write_en, dc_in_wlen}); end
        checks++; if (dc_in_wdata !== 64'h55) begin errors++; $display("FAIL ic_wdata got %h exp 55", dc_in_wdata); end
        p_addr = 64'h3000; p_wdata = 64'hAA;
        tick();
        checks++; if (dc_in_addr !== 64'h2000) begin errors++; $display("FAIL ic_addr_held got %h exp 2000", dc_in_addr); end
        checks++; if (dc_in_wdata !== 64'h55) begin errors++; $display("FAIL ic_wdata_held got %h exp 55", dc_in_wdata); end
        dc_out_write_done = 1;
        #1;
        checks++; if ({p_write_done, m_write_done, p_rvalid} !== 3'b100)
            begin errors++; $display("FAIL ic_wdone got %b exp 100", {p_write_done, m_write_done, p_rvalid}); end
        tick();
        dc_out_write_done = 0; p_en = 0; p_write_en = 0;
        #1;
        checks++; if (p_write_done !== 1'b0) begin errors++; $display("FAIL ic_wdone_once got %b exp 0", p_write_done); end
        tick();
    endtask

    task automatic test_abort();
        m_en = 1; m_addr = 64'h4000; p_en = 1; p_addr = 64'h5000;
        tick();
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL ab_owner got %b exp 0", owner); end
        tick();
        m_en = 0;
        tick();
        checks++; if (dc_en !== 1'b1) begin errors++; $display("FAIL ab_dc_en_hold got %b exp 1", dc_en); end
        tick();
        dc_out_rvalid = 1; dc_out_rdata = 64'h77;
        #1;
        checks++; if ({m_rvalid, p_rvalid} !== 2'b00) begin errors++; $display("FAIL ab_discard got %b exp 00", {m_rvalid, p_rvalid}); end
        checks++; if (m_rdata !== '0) begin errors++; $display("FAIL ab_rdata got %h exp 0", m_rdata); end
        tick();
        dc_out_rvalid = 0;
        #1;
        checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL ab_release got %b exp 0", dc_en); end
        tick();
        checks++; if (dc_en !== 1'b0) begin errors++; $display("FAIL ab_idle got %b exp 0", dc_en); end
        tick();
        checks++; if ({dc_en, owner} !== 2'b11) begin errors++; $display("FAIL ab_ptw_grant got %b exp 11", {dc_en, owner}); end
        checks++; if (dc_in_addr !== 64'h5000) begin errors++; $display("FAIL ab_ptw_addr got %h exp 5000", dc_in_addr); end
        dc_out_rvalid = 1; dc_out_rdata = 64'h99;
        #1;
        checks++; if ({p_rvalid, p_rdata} !== {1'b1, 64'h99}) begin errors++; $display("FAIL ab_ptw_resp got %b/%h exp 1/99", p_rvalid, p_rdata); end
        tick();
        dc_out_rvalid = 0; p_en = 0;
        tick();
    endtask

    task automatic test_done_abort_same_cycle();
        m_en = 1; m_addr = 64'h6000;
        tick();
        m_en = 0; dc_out_rvalid = 1; dc_out_rdata = 64'h1234;
        #1;
        checks++; if ({m_rvalid, m_rdata} !== {1'b1, 64'h1234}) begin errors++; $display("FAIL da_resp got %b/%h exp 1/1234", m_rvalid, m_rdata); end
        tick();
        dc_out_rvalid = 0;
        tick();
    endtask

    task automatic test_page_fault();
        p_en = 1; p_addr = 64'h7000; p_write_en = 0;
        tick();
        tick();
        dc_out_rvalid = 1; dc_out_page_fault = 1; dc_out_rdata = 64'hABC;
        #1;
        checks++; if ({p_page_fault, p_rvalid} !== 2'b11) begin errors++; $display("FAIL pf_ptw got %b exp 11", {p_page_fault, p_rvalid}); end
        checks++; if ({m_page_fault, m_rvalid} !== 2'b00) begin errors++; $display("FAIL pf_mem got %b exp 00", {m_page_fault, m_rvalid}); end
        tick();
        dc_out_rvalid = 0; dc_out_page_fault = 0; p_en = 0;
        #1;
        checks++; if (p_page_fault !== 1'b0) begin errors++; $display("FAIL pf_once got %b exp 0", p_page_fault); end
        tick();
    endtask

    task automatic test_idle_noise();
        dc_out_rvalid = 1; dc_out_write_done = 1; dc_out_page_fault = 1; dc_out_rdata = 64'hF00D;
        #1;
        checks++; if ({m_rvalid, m_write_done, m_page_fault, p_rvalid, p_write_done, p_page_fault} !== 6'b0)
            begin errors++; $display("FAIL idle_noise got %b exp 000000",
                {m_rvalid, m_write_done, m_page_fault, p_rvalid, p_write_done, p_page_fault}); end
        checks++; if ({m_rdata, p_rdata} !== '0) begin errors++; $display("FAIL idle_rdata got %h/%h exp 0", m_rdata, p_rdata); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
        dc_out_rvalid = 0; dc_out_write_done = 0; dc_out_page_fault = 0; dc_out_rdata = '0;
    endtask

    task automatic test_watchdog();
        m_en = 1; m_addr = 64'h8000;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early[%0d] got %b exp 0", k, timeout_err); end
        end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_set got %b exp 1", timeout_err); end
        tick();
        tick();
        checks++; if ({timeout_err, dc_en, busy} !== 3'b111) begin errors++; $display("FAIL wd_sticky got %b exp 111", {timeout_err, dc_en, busy}); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({dc_en, busy, timeout_err} !== 3'b000) begin errors++; $display("FAIL wd_async_rst got %b exp 000", {dc_en, busy, timeout_err}); end
        m_en = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        checks++; if ({dc_en, m_rvalid, owner} !== 3'b001) begin errors++; $display("FAIL wd_post_rst got %b exp 001", {dc_en, m_rvalid, owner}); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_input_change();
        test_abort();
        test_done_abort_same_cycle();
        test_page_fault();
        test_idle_noise();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
